counter_updn_mod: RTL and testbench

COUNTER_UPDN_MOD -- requirements
Module: counter_updn_mod

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_prescale.sv | 21 ++
 rtl/counter_updn_mod.sv | 54 +++++
 tb/tb_counter_updn_mod.sv | 127 ++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants, parameter defaults and prescaler width helper
package counter_pkg;
   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;
   localparam int DEF_WIDTH = 4;
   localparam longint DEF_MODULUS = 16;
   localparam int DEF_PRESCALE = 1;
   // Phase register needs at least one bit even when PRESCALE is 1
   function automatic int pre_width(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction
endpackage

// File: rtl/counter_prescale.sv
// counter_prescale: one-cycle tick on every PRESCALE-th enabled cycle; sync_rst restarts the phase
module counter_prescale
   import counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sync_rst,
   output logic tick
);
   localparam int PW = pre_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
   logic [PW-1:0] phase;
   assign tick = en && phase == LAST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) phase <= '0;
      else if (sync_rst || tick) phase <= '0;
      else if (en) phase <= phase + PW'(1);
endmodule

// File: rtl/counter_updn_mod.sv
// counter_updn_mod: modulo up/down counter with prescaler, load, clear and terminal-count pulse
// COUNTER_SATURATE_EN: saturate at the range ends instead of wrapping
module counter_updn_mod
   import counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter longint MODULUS = DEF_MODULUS,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0] MODW = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   logic tick, hit;
   logic [WIDTH-1:0] nxt;
   counter_prescale #(.PRESCALE(PRESCALE)) u_pre (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .sync_rst(clr | load),
      .tick(tick)
   );
   always_comb begin
      hit = (up == CNT_UP) ? count == MAX : count == '0;
`ifdef COUNTER_SATURATE_EN
      nxt = hit ? count : (up == CNT_UP) ? count + ONE : count - ONE;
`else
      nxt = (up == CNT_UP) ? (hit ? '0 : count + ONE) : (hit ? MAX : count - ONE);
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count <= '0;
         tc <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tc <= 1'b0;
      end else if (load) begin
         count <= ({1'b0, d} < MODW) ? d : MAX;
         tc <= 1'b0;
      end else begin
         count <= tick ? nxt : count;
         tc <= tick && hit;
      end
endmodule

// File: tb/tb_counter_updn_mod.sv
// tb_counter_updn_mod: scoreboard bench; A is MODULUS=10/PRESCALE=1, B is MODULUS=10/PRESCALE=3
module tb_counter_updn_mod;
   import counter_pkg::*;
   typedef struct {
      int         due;
      bit         sel;
      logic [3:0] c;
      logic       t;
      string      name;
   } exp_t;
   exp_t q[$];
   int cyc = 0, total = 0, bad = 0;
   logic clk = 0, rst_n = 0;
   logic en_a = 0, up_a = 0, load_a = 0, clr_a = 0;
   logic en_b = 0, up_b = 0, load_b = 0, clr_b = 0;
   logic [3:0] d_a = 0, d_b = 0, count_a, count_b;
   logic tc_a, tc_b;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   counter_updn_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .up(up_a), .load(load_a), .clr(clr_a),
      .d(d_a), .count(count_a), .tc(tc_a)
   );
   counter_updn_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .up(up_b), .load(load_b), .clr(clr_b),
      .d(d_b), .count(count_b), .tc(tc_b)
   );

   // Monitor: pops every expectation due in the current cycle
   always @(negedge clk) begin
      exp_t e;
      logic [3:0] c;
      logic t;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         c = e.sel ? count_b : count_a;
         t = e.sel ? tc_b : tc_a;
         total++;
         if (e.due != cyc || c !== e.c || t !== e.t) begin
            bad++;
            $display("FAIL %s: got count=%0d tc=%0d, want count=%0d tc=%0d (due %0d, now %0d)",
                     e.name, c, t, e.c, e.t, e.due, cyc);
         end
      end
   end

   task automatic drv_a(input logic e, u, l, c, input logic [3:0] dv, ec, input logic et, input string n);
      @(negedge clk);
      en_a = e; up_a = u; load_a = l; clr_a = c; d_a = dv;
      q.push_back('{cyc + 1, 1'b0, ec, et, n});
   endtask

   task automatic drv_b(input logic e, u, l, c, input logic [3:0] dv, ec, input logic et, input string n);
      @(negedge clk);
      en_b = e; up_b = u; load_b = l; clr_b = c; d_b = dv;
      q.push_back('{cyc + 1, 1'b1, ec, et, n});
   endtask

   initial begin
      drv_a(1, 1, 0, 0, 0, 0, 0, "reset_hold");
      @(negedge clk);
      rst_n = 1;
      en_a = 0;
      drv_a(0, 1, 0, 0, 0, 0, 0, "reset_state");
      for (int i = 1; i <= 12; i++)
         drv_a(1, CNT_UP, 0, 0, 0, 4'(i % 10), i == 10, "count_up");
      drv_a(1, CNT_DN, 1, 0, 3, 3, 0, "load3");
      drv_a(1, CNT_DN, 0, 0, 0, 2, 0, "down");
      drv_a(1, CNT_DN, 0, 0, 0, 1, 0, "down");
      drv_a(1, CNT_DN, 0, 0, 0, 0, 0, "down");
      drv_a(1, CNT_DN, 0, 0, 0, 9, 1, "down_wrap");
      drv_a(1, CNT_DN, 0, 0, 0, 8, 0, "down_after_wrap");
      drv_a(0, CNT_DN, 1, 0, 12, 9, 0, "load_clamp");
      drv_a(1, CNT_UP, 1, 1, 5, 0, 0, "clr_over_load");
      drv_a(1, CNT_UP, 1, 0, 5, 5, 0, "load_over_step");
      drv_a(0, CNT_UP, 0, 0, 0, 5, 0, "hold");
      drv_a(1, CNT_UP, 0, 0, 0, 6, 0, "up6");
      drv_a(1, CNT_UP, 0, 0, 0, 7, 0, "up7");
      @(negedge clk);
      en_a = 0;
      @(posedge clk);
      #1 rst_n = 0;
      q.push_back('{cyc, 1'b0, 4'd0, 1'b0, "async_rst"});
      @(negedge clk);
      rst_n = 1;
      drv_a(1, CNT_UP, 0, 0, 0, 1, 0, "restart1");
      drv_a(1, CNT_UP, 0, 0, 0, 2, 0, "restart2");
      drv_a(1, CNT_DN, 0, 0, 0, 1, 0, "dir_change");
`ifdef COUNTER_SATURATE_EN
      drv_a(0, CNT_UP, 1, 0, 8, 8, 0, "sat_load8");
      drv_a(1, CNT_UP, 0, 0, 0, 9, 0, "sat_up1");
      drv_a(1, CNT_UP, 0, 0, 0, 9, 1, "sat_up2");
      drv_a(1, CNT_UP, 0, 0, 0, 9, 1, "sat_up3");
      drv_a(0, CNT_DN, 1, 0, 0, 0, 0, "sat_load0");
      drv_a(1, CNT_DN, 0, 0, 0, 0, 1, "sat_dn");
`else
      drv_a(0, CNT_UP, 1, 0, 9, 9, 0, "wrap_load9");
      drv_a(1, CNT_UP, 0, 0, 0, 0, 1, "wrap_up");
`endif
      drv_a(0, CNT_UP, 0, 0, 0, 0, 0, "tc_one_cycle");
      drv_b(0, CNT_UP, 0, 1, 0, 0, 0, "b_clr");
      for (int i = 1; i <= 9; i++)
         drv_b(1, CNT_UP, 0, 0, 0, 4'(i / 3), 0, "b_prescale");
      drv_b(1, CNT_UP, 0, 0, 0, 3, 0, "b_phase1");
      drv_b(0, CNT_UP, 0, 0, 0, 3, 0, "b_pause");
      drv_b(0, CNT_UP, 0, 0, 0, 3, 0, "b_pause");
      drv_b(1, CNT_UP, 0, 0, 0, 3, 0, "b_phase2");
      drv_b(1, CNT_UP, 0, 0, 0, 4, 0, "b_step");
      drv_b(1, CNT_UP, 0, 0, 0, 4, 0, "b_phase1b");
      drv_b(1, CNT_UP, 1, 0, 2, 2, 0, "b_load_phase");
      drv_b(1, CNT_UP, 0, 0, 0, 2, 0, "b_after_load");
      drv_b(1, CNT_UP, 0, 0, 0, 2, 0, "b_after_load");
      drv_b(1, CNT_UP, 0, 0, 0, 3, 0, "b_step_after_load");
      drv_b(0, CNT_UP, 0, 0, 0, 3, 0, "b_idle");
      repeat (3) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
